// File: rtl/pool1d_window_buffer_if.sv
// Streaming handshake bundle for the 1-D pooling window buffer: one element in, one K-wide window out.
interface pool1d_window_buffer_if #(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned KERNEL_SIZE = 2
) ();
    logic [DATA_W-1:0] data_in_0 [0:0];
    logic              data_in_0_valid;
    logic              data_in_0_ready;
    logic [DATA_W-1:0] data_out_0 [0:KERNEL_SIZE-1];
    logic              data_out_0_valid;
    logic              data_out_0_ready;

    // Producer of row elements / consumer of windows
    modport master (
        output data_in_0,
        output data_in_0_valid,
        output data_out_0_ready,
        input  data_in_0_ready,
        input  data_out_0,
        input  data_out_0_valid
    );

    // The window buffer itself
    modport slave (
        input  data_in_0,
        input  data_in_0_valid,
        input  data_out_0_ready,
        output data_in_0_ready,
        output data_out_0,
        output data_out_0_valid
    );
endinterface

// File: rtl/pool1d_window_buffer.sv
// Sliding-window buffer for 1-D pooling: walks a zero-padded row one element per
// advance and presents every STRIDE-th complete K-element window on the output.
module pool1d_window_buffer #(
    parameter int unsigned DATA_IN_0_PRECISION_0       = 8,
    parameter int unsigned DATA_IN_0_PRECISION_1       = 3,
    parameter int unsigned DATA_IN_0_TENSOR_SIZE_DIM_0 = 8,
    parameter int unsigned KERNEL_SIZE                 = 2,
    parameter int unsigned STRIDE                      = 2,
    parameter int unsigned PADDING                     = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    pool1d_window_buffer_if.slave bus
);
    localparam int unsigned DW        = DATA_IN_0_PRECISION_0;
    localparam int unsigned PAD_LEN   = DATA_IN_0_TENSOR_SIZE_DIM_0 + 2 * PADDING;
    localparam int unsigned PAD_END   = PADDING + DATA_IN_0_TENSOR_SIZE_DIM_0;
    localparam int unsigned NUM_WIN   = (PAD_LEN - KERNEL_SIZE) / STRIDE + 1;
    localparam int unsigned POS_W     = $clog2(PAD_LEN + 1);
    localparam int unsigned WIN_CNT_W = $clog2(NUM_WIN + 1);
    localparam int unsigned PH_W      = $clog2(STRIDE + 1);

    // Reject parameter sets that cannot form even one window
    if (KERNEL_SIZE == 0 || STRIDE == 0 || DATA_IN_0_TENSOR_SIZE_DIM_0 == 0 ||
        KERNEL_SIZE > PAD_LEN || DATA_IN_0_PRECISION_1 > DATA_IN_0_PRECISION_0) begin : g_bad_params
        $error("pool1d_window_buffer: illegal parameter combination");
    end

    logic [POS_W-1:0]     pos_q, pos_d;
    logic [WIN_CNT_W-1:0] wcnt_q, wcnt_d;
    logic [PH_W-1:0]      phase_q, phase_d;
    logic [DW-1:0]        win_q [0:KERNEL_SIZE-1];
    logic [DW-1:0]        win_d [0:KERNEL_SIZE-1];
    logic                 valid_q, valid_d;

    logic                 out_free;
    logic                 in_pad;
    logic                 advance;
    logic                 row_end;
    logic                 past_first;
    logic                 win_done;
    logic [DW-1:0]        elem;

    // Advance conditions: output slot free, and either a pad slot or a real element available
    always_comb begin
        out_free   = !valid_q || bus.data_out_0_ready;
        in_pad     = (pos_q < POS_W'(PADDING)) || (pos_q >= POS_W'(PAD_END));
        advance    = rst && out_free && (in_pad || bus.data_in_0_valid);
        elem       = in_pad ? '0 : bus.data_in_0[0];
        row_end    = (pos_q == POS_W'(PAD_LEN - 1));
        past_first = (pos_q >= POS_W'(KERNEL_SIZE - 1));
        win_done   = past_first && (phase_q == '0) && (wcnt_q < WIN_CNT_W'(NUM_WIN));
    end

    // Input is only accepted on real-data positions and never while in reset
    assign bus.data_in_0_ready  = rst && out_free && !in_pad;
    assign bus.data_out_0_valid = valid_q;

    // Window registers drive the output directly; index 0 is the oldest element
    for (genvar g = 0; g < int'(KERNEL_SIZE); g++) begin : g_out
        assign bus.data_out_0[g] = win_q[g];
    end

    // Next-state: shift window, step row position / stride phase / window count, manage valid
    always_comb begin
        pos_d   = pos_q;
        wcnt_d  = wcnt_q;
        phase_d = phase_q;
        win_d   = win_q;
        valid_d = valid_q;

        if (valid_q && bus.data_out_0_ready) begin
            valid_d = 1'b0;
        end

        if (advance) begin
            for (int i = 0; i < int'(KERNEL_SIZE) - 1; i++) begin
                win_d[i] = win_q[i+1];
            end
            win_d[KERNEL_SIZE-1] = elem;

            if (win_done) begin
                valid_d = 1'b1;
            end

            if (row_end) begin
                pos_d   = '0;
                wcnt_d  = '0;
                phase_d = '0;
            end else begin
                pos_d = pos_q + 1'b1;
                if (win_done) begin
                    wcnt_d = wcnt_q + 1'b1;
                end
                if (past_first) begin
                    phase_d = (phase_q == PH_W'(STRIDE - 1)) ? '0 : phase_q + 1'b1;
                end
            end
        end
    end

    // State register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            pos_q   <= '0;
            wcnt_q  <= '0;
            phase_q <= '0;
            valid_q <= 1'b0;
            for (int i = 0; i < int'(KERNEL_SIZE); i++) begin
                win_q[i] <= '0;
            end
        end else begin
            pos_q   <= pos_d;
            wcnt_q  <= wcnt_d;
            phase_q <= phase_d;
            valid_q <= valid_d;
            for (int i = 0; i < int'(KERNEL_SIZE); i++) begin
                win_q[i] <= win_d[i];
            end
        end
    end
endmodule

// File: tb/tb_pool1d_window_buffer.sv
// Directed bench for pool1d_window_buffer across four parameter sets sharing one stimulus path.
module tb_pool1d_window_buffer;
    localparam int unsigned DW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b1;
    logic          tx_done = 1'b0;
    int            sel = 0;
    int            cyc = 0;
    int            n_checks = 0;
    int            n_fail = 0;
    int            in_cnt = 0;
    logic [23:0]   got_q [$];
    logic [23:0]   exp_q [$];

    logic          cur_in_ready;
    logic          cur_out_valid;
    logic [23:0]   cur_win;
    logic          prev_stall = 1'b0;
    logic [23:0]   prev_win = '0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // b0: N=8 K=2 S=2 P=0 | b1: N=4 K=3 S=1 P=1 | b2: N=7 K=2 S=2 P=0 | b3: N=8 K=3 S=2 P=1
    pool1d_window_buffer_if #(.DATA_W(DW), .KERNEL_SIZE(2)) b0 ();
    pool1d_window_buffer_if #(.DATA_W(DW), .KERNEL_SIZE(3)) b1 ();
    pool1d_window_buffer_if #(.DATA_W(DW), .KERNEL_SIZE(2)) b2 ();
    pool1d_window_buffer_if #(.DATA_W(DW), .KERNEL_SIZE(3)) b3 ();

    pool1d_window_buffer #(.DATA_IN_0_PRECISION_0(DW), .DATA_IN_0_PRECISION_1(3),
        .DATA_IN_0_TENSOR_SIZE_DIM_0(8), .KERNEL_SIZE(2), .STRIDE(2), .PADDING(0))
        u0 (.clk(clk), .rst(rst), .bus(b0));
    pool1d_window_buffer #(.DATA_IN_0_PRECISION_0(DW), .DATA_IN_0_PRECISION_1(3),
        .DATA_IN_0_TENSOR_SIZE_DIM_0(4), .KERNEL_SIZE(3), .STRIDE(1), .PADDING(1))
        u1 (.clk(clk), .rst(rst), .bus(b1));
    pool1d_window_buffer #(.DATA_IN_0_PRECISION_0(DW), .DATA_IN_0_PRECISION_1(3),
        .DATA_IN_0_TENSOR_SIZE_DIM_0(7), .KERNEL_SIZE(2), .STRIDE(2), .PADDING(0))
        u2 (.clk(clk), .rst(rst), .bus(b2));
    pool1d_window_buffer #(.DATA_IN_0_PRECISION_0(DW), .DATA_IN_0_PRECISION_1(3),
        .DATA_IN_0_TENSOR_SIZE_DIM_0(8), .KERNEL_SIZE(3), .STRIDE(2), .PADDING(1))
        u3 (.clk(clk), .rst(rst), .bus(b3));

    // Shared stimulus; only the selected instance sees valid input
    always_comb begin
        b0.data_in_0[0]     = in_data;
        b1.data_in_0[0]     = in_data;
        b2.data_in_0[0]     = in_data;
        b3.data_in_0[0]     = in_data;
        b0.data_in_0_valid  = in_valid && (sel == 0);
        b1.data_in_0_valid  = in_valid && (sel == 1);
        b2.data_in_0_valid  = in_valid && (sel == 2);
        b3.data_in_0_valid  = in_valid && (sel == 3);
        b0.data_out_0_ready = out_ready;
        b1.data_out_0_ready = out_ready;
        b2.data_out_0_ready = out_ready;
        b3.data_out_0_ready = out_ready;
    end

    // Observe the selected instance; windows packed oldest-first into the low bytes
    always_comb begin
        cur_in_ready  = 1'b0;
        cur_out_valid = 1'b0;
        cur_win       = '0;
        case (sel)
            0: begin
                cur_in_ready  = b0.data_in_0_ready;
                cur_out_valid = b0.data_out_0_valid;
                cur_win       = {8'h00, b0.data_out_0[0], b0.data_out_0[1]};
            end
            1: begin
                cur_in_ready  = b1.data_in_0_ready;
                cur_out_valid = b1.data_out_0_valid;
                cur_win       = {b1.data_out_0[0], b1.data_out_0[1], b1.data_out_0[2]};
            end
            2: begin
                cur_in_ready  = b2.data_in_0_ready;
                cur_out_valid = b2.data_out_0_valid;
                cur_win       = {8'h00, b2.data_out_0[0], b2.data_out_0[1]};
            end
            default: begin
                cur_in_ready  = b3.data_in_0_ready;
                cur_out_valid = b3.data_out_0_valid;
                cur_win       = {b3.data_out_0[0], b3.data_out_0[1], b3.data_out_0[2]};
            end
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Monitor: log accepted windows, count accepted inputs, verify hold under back-pressure
    always @(negedge clk) begin
        if (!rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", 32'(cur_out_valid), 32'd1);
                check("hold_data", 32'(cur_win), 32'(prev_win));
            end
            if (cur_out_valid && out_ready) got_q.push_back(cur_win);
            if (in_valid && cur_in_ready) in_cnt++;
            prev_stall = cur_out_valid && !out_ready;
            prev_win   = cur_win;
        end
    end

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int n);
        repeat (n) sync();
    endtask

    task automatic do_reset(input int s);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        rst       = 1'b0;
        sel       = s;
        @(posedge clk);
        repeat (2) begin
            @(negedge clk);
            check("rst_in_ready", 32'(cur_in_ready), 32'd0);
            check("rst_out_valid", 32'(cur_out_valid), 32'd0);
            check("rst_window", 32'(cur_win), 32'd0);
        end
        sync();
        rst = 1'b1;
    endtask

    task automatic send(input logic [DW-1:0] v);
        int t;
        t        = 0;
        in_data  = v;
        in_valid = 1'b1;
        @(negedge clk);
        while (!cur_in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!cur_in_ready) check("send_timeout", 32'(cur_in_ready), 32'd1);
        sync();
        in_valid = 1'b0;
    endtask

    task automatic check_wins(input string tag, input int base);
        check({tag, "_count"}, 32'(got_q.size() - base), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && base + i < got_q.size(); i++) begin
            check($sformatf("%s_w%0d", tag, i), 32'(got_q[base+i]), 32'(exp_q[i]));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int c0;
        int n0;

        // Free flow, one element per cycle
        do_reset(0);
        base = got_q.size(); n0 = in_cnt; c0 = cyc;
        for (int v = 1; v <= 8; v++) send(DW'(v));
        check("t1_cycles", 32'(cyc - c0), 32'd8);
        drain(3);
        exp_q = '{24'h000102, 24'h000304, 24'h000506, 24'h000708};
        check_wins("t1", base);
        check("t1_inputs", 32'(in_cnt - n0), 32'd8);

        // Output latency: valid exactly one cycle after the second element
        do_reset(0);
        send(8'd1);
        @(negedge clk);
        check("lat_valid_after_1", 32'(cur_out_valid), 32'd0);
        sync();
        send(8'd2);
        @(negedge clk);
        check("lat_valid_after_2", 32'(cur_out_valid), 32'd1);
        check("lat_window", 32'(cur_win), 32'h000102);
        sync();

        // Back-pressure on the first window
        do_reset(0);
        base = got_q.size();
        send(8'd1);
        send(8'd2);
        out_ready = 1'b0;
        in_data   = 8'd3;
        in_valid  = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("stall_valid", 32'(cur_out_valid), 32'd1);
            check("stall_window", 32'(cur_win), 32'h000102);
            check("stall_in_ready", 32'(cur_in_ready), 32'd0);
        end
        sync();
        out_ready = 1'b1;
        for (int v = 3; v <= 8; v++) send(DW'(v));
        drain(3);
        exp_q = '{24'h000102, 24'h000304, 24'h000506, 24'h000708};
        check_wins("t2", base);

        // Padding, K=3 S=1 P=1
        do_reset(1);
        base = got_q.size(); n0 = in_cnt;
        send(8'd10); send(8'd20); send(8'd30); send(8'd40);
        drain(4);
        exp_q = '{24'h000A14, 24'h0A141E, 24'h141E28, 24'h1E2800};
        check_wins("t3", base);
        check("t3_inputs", 32'(in_cnt - n0), 32'd4);

        // Odd row length, two rows, trailing element discarded
        do_reset(2);
        base = got_q.size(); n0 = in_cnt;
        for (int v = 1; v <= 7; v++) send(DW'(v));
        for (int v = 11; v <= 17; v++) send(DW'(v));
        drain(3);
        exp_q = '{24'h000102, 24'h000304, 24'h000506, 24'h000B0C, 24'h000D0E, 24'h000F10};
        check_wins("t4", base);
        check("t4_inputs", 32'(in_cnt - n0), 32'd14);

        // Reset in the middle of a row
        do_reset(0);
        send(8'd1); send(8'd2); send(8'd3);
        do_reset(0);
        base = got_q.size();
        for (int v = 5; v <= 12; v++) send(DW'(v));
        drain(3);
        exp_q = '{24'h000506, 24'h000708, 24'h00090A, 24'h000B0C};
        check_wins("t5", base);

        // Random valid gaps and ready toggling, K=3 S=2 P=1, two rows
        do_reset(3);
        base    = got_q.size();
        tx_done = 1'b0;
        fork
            begin
                for (int r = 0; r < 2; r++) begin
                    for (int v = 1; v <= 8; v++) begin
                        send(DW'(r * 20 + v));
                        repeat ($urandom_range(0, 2)) sync();
                    end
                end
                tx_done = 1'b1;
            end
            begin
                while (!tx_done) begin
                    sync();
                    out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        out_ready = 1'b1;
        drain(6);
        exp_q = '{24'h000102, 24'h020304, 24'h040506, 24'h060708,
                  24'h001516, 24'h161718, 24'h18191A, 24'h1A1B1C};
        check_wins("t6", base);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/pool1d_window_buffer.md
POOL1D_WINDOW_BUFFER -- requirements
Module: pool1d_window_buffer

Interface
REQ-001 SHALL have parameter DATA_IN_0_PRECISION_0, default 8, element total bit width.
REQ-002 SHALL have parameter DATA_IN_0_PRECISION_1, default 3, fractional bits; pass-through only, no arithmetic effect.
REQ-003 SHALL have parameter DATA_IN_0_TENSOR_SIZE_DIM_0, default 8, unpadded row length N (>=1).
REQ-004 SHALL have parameter KERNEL_SIZE, default 2, window length K (>=1, K <= N+2*PADDING).
REQ-005 SHALL have parameter STRIDE, default 2, window step S (>=1).
REQ-006 SHALL have parameter PADDING, default 0, zero elements P added at each row end.
REQ-007 SHALL have port clk, input, 1 bit, single clock; all state updates on its rising edge.
REQ-008 SHALL have port rst, input, 1 bit, reset; synchronous and active-low (asserted when 0, sampled on rising clk).
REQ-009 SHALL have port data_in_0, input, DATA_IN_0_PRECISION_0 x 1 (unpacked array [0:0]), one row element per beat.
REQ-010 SHALL have port data_in_0_valid, input, 1 bit; data_in_0_ready, output, 1 bit.
REQ-011 SHALL have port data_out_0, output, DATA_IN_0_PRECISION_0 x K (unpacked array), one window; index 0 = oldest element.
REQ-012 SHALL have port data_out_0_valid, output, 1 bit; data_out_0_ready, input, 1 bit.

Function
REQ-013 SHALL hold a K-deep window shift register; data_out_0 SHALL be driven directly from it.
REQ-014 SHALL keep position counter pos over padded row, 0..N+2P-1, and window counter over 0..W-1, W = floor((N+2P-K)/S)+1.
REQ-015 SHALL define advance = (!data_out_0_valid || data_out_0_ready) && (pos in pad region || data_in_0_valid).
REQ-016 SHALL, for pos < P or pos >= P+N, shift in zero on advance without consuming input.
REQ-017 SHALL drive data_in_0_ready = (!data_out_0_valid || data_out_0_ready) && P <= pos < P+N; combinational, no dependence on data_in_0_valid.
REQ-018 SHALL, on advance, shift element into window (oldest drops out of index 0) and increment pos, wrapping to 0 after N+2P-1.
REQ-019 SHALL set data_out_0_valid on the cycle after an advance where pos >= K-1, (pos-(K-1)) mod S == 0, and window counter < W; latency = 1 cycle from completing element.
REQ-020 SHALL clear data_out_0_valid after handshake (valid && ready) unless a new window completes in the same cycle, in which case valid stays 1 with new contents.
REQ-021 SHALL hold data_out_0 and data_out_0_valid stable while valid=1 and ready=0.
REQ-022 SHALL consume and discard trailing elements past the last window end (no window emitted for them).
REQ-023 SHALL reset window counter to 0 on row wrap; next row starts fresh with P leading zeros, no window spans two rows.
REQ-024 SHALL sustain one element per cycle when data_out_0_ready=1 and inputs are valid.

Reset
REQ-025 SHALL, while rst=0, clear pos, window counter, all window registers (to 0) and data_out_0_valid; data_in_0_ready SHALL be 0.
REQ-026 SHALL, on rst=0 mid-row, discard the partial row and any pending window; first beat after release is element 0 of a new row.

Verification
REQ-027 N=8,K=2,S=2,P=0, inputs 1..8, ready=1 -> windows (1,2),(3,4),(5,6),(7,8), each valid one cycle after its second element.
REQ-028 N=4,K=3,S=1,P=1, inputs 10,20,30,40 -> windows (0,10,20),(10,20,30),(20,30,40),(30,40,0); no extra input consumed for padding.
REQ-029 N=8,K=2,S=2, data_out_0_ready=0 for 5 cycles at first window -> (1,2) held stable, data_in_0_ready=0, no loss; resumes after ready.
REQ-030 N=7,K=2,S=2, two rows 1..7 then 11..17 -> (1,2),(3,4),(5,6),(11,12),(13,14),(15,16); elements 7 and 17 accepted, discarded.
REQ-031 rst=0 after inputs 1,2,3 of N=8 row -> valid=0, ready=0 during reset; after release inputs 5..12 -> (5,6),(7,8),(9,10),(11,12).
REQ-032 Random valid/ready toggling, N=8,K=3,S=2,P=1 -> window sequence identical to REQ-024-style free-flow run; no duplicate or dropped windows.
